// File: rtl/jsi_arb_pkg.sv
// Shared types and widths for the uio pad-bank arbiter.
package jsi_arb_pkg;

    localparam int ID_W    = 2;
    localparam int LEN_W   = 2;
    localparam int STALL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TURN = 2'd1,
        ST_XFER = 2'd2
    } state_t;

    typedef logic [ID_W-1:0]  id_t;
    typedef logic [LEN_W-1:0] beat_t;

endpackage

// File: rtl/jsi_rr_pick.sv
// Round-robin picker: first valid requester at or after last+1, wrapping at NREQ.
import jsi_arb_pkg::*;

module jsi_rr_pick #(
    parameter int NREQ = 3
) (
    input  logic [NREQ-1:0] valid_i,
    input  id_t             last_i,
    output logic            found_o,
    output id_t             idx_o
);

    logic [2:0] cand;
    logic       found;
    id_t        idx;

    always_comb begin
        cand  = '0;
        found = 1'b0;
        idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = {1'b0, last_i} + 3'(k);
            if (cand >= 3'(NREQ)) begin
                cand = cand - 3'(NREQ);
            end
            if (!found && valid_i[cand]) begin
                found = 1'b1;
                idx   = cand[ID_W-1:0];
            end
        end
        found_o = found;
        idx_o   = idx;
    end

endmodule

// File: rtl/jsi_uio_arbiter.sv
// Round-robin owner of the bidirectional uio pad bank: bursts of 1-4 beats
// with a pad-idle turnaround between owners and a stall timeout.
//
// state | meaning
// IDLE  | no owner, pads released, pick next requester
// TURN  | owner granted, pads idle for TURNAROUND cycles
// XFER  | owner transfers beats; write drives pads, read samples them
import jsi_arb_pkg::*;

module jsi_uio_arbiter #(
    parameter int NREQ       = 3,
    parameter int TURNAROUND = 1,
    parameter int STALL_MAX  = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ena_i,
    input  logic [NREQ-1:0]   req_valid_i,
    input  logic [NREQ-1:0]   req_dir_i,
    input  logic [2*NREQ-1:0] req_len_i,
    input  logic [8*NREQ-1:0] req_data_i,
    output logic [NREQ-1:0]   req_ready_o,
    output logic [NREQ-1:0]   grant_o,
    output logic              busy_o,
    output logic              rsp_valid_o,
    output logic [7:0]        rsp_data_o,
    output logic [1:0]        rsp_id_o,
    output logic              abort_o,
    input  logic [7:0]        uio_in_i,
    output logic [7:0]        uio_out_o,
    output logic [7:0]        uio_oe_o
);

    localparam logic [1:0]         TURN_LOAD = (TURNAROUND > 0) ? 2'(TURNAROUND - 1) : 2'd0;
    localparam logic [STALL_W-1:0] STALL_TC  = STALL_W'(STALL_MAX - 1);
    localparam id_t                LAST_RST  = id_t'(NREQ - 1);

    state_t              state_q, state_d;
    id_t                 owner_q, owner_d;
    id_t                 last_q, last_d;
    logic                dir_q, dir_d;
    beat_t               len_q, len_d;
    beat_t               beat_q, beat_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [1:0]          turn_q, turn_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [7:0]          rsp_data_q, rsp_data_d;
    id_t                 rsp_id_q, rsp_id_d;

    logic                pick_found;
    id_t                 pick_idx;
    logic                beat;

    jsi_rr_pick #(.NREQ(NREQ)) u_pick (
        .valid_i (req_valid_i),
        .last_i  (last_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    assign beat = (state_q == ST_XFER) && req_valid_i[owner_q];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= ST_IDLE;
            owner_q     <= '0;
            last_q      <= LAST_RST;
            dir_q       <= 1'b0;
            len_q       <= '0;
            beat_q      <= '0;
            stall_q     <= '0;
            turn_q      <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_id_q    <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            dir_q       <= dir_d;
            len_q       <= len_d;
            beat_q      <= beat_d;
            stall_q     <= stall_d;
            turn_q      <= turn_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_id_q    <= rsp_id_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        dir_d       = dir_q;
        len_d       = len_q;
        beat_d      = beat_q;
        stall_d     = stall_q;
        turn_d      = turn_q;
        rsp_valid_d = 1'b0;
        rsp_data_d  = rsp_data_q;
        rsp_id_d    = rsp_id_q;
        abort_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ena_i && pick_found) begin
                    owner_d = pick_idx;
                    dir_d   = req_dir_i[pick_idx];
                    len_d   = req_len_i[LEN_W*int'(pick_idx) +: LEN_W];
                    beat_d  = '0;
                    stall_d = '0;
                    turn_d  = TURN_LOAD;
                    state_d = (TURNAROUND == 0) ? ST_XFER : ST_TURN;
                end
            end
            ST_TURN: begin
                if (turn_q == 2'd0) begin
                    state_d = ST_XFER;
                end else begin
                    turn_d = turn_q - 2'd1;
                end
            end
            ST_XFER: begin
                if (beat) begin
                    stall_d = '0;
                    beat_d  = beat_q + 2'd1;
                    if (!dir_q) begin
                        rsp_valid_d = 1'b1;
                        rsp_data_d  = uio_in_i;
                        rsp_id_d    = owner_q;
                    end
                    if (beat_q == len_q) begin
                        state_d = ST_IDLE;
                        last_d  = owner_q;
                    end
                end else if (stall_q == STALL_TC) begin
                    // A timed-out owner goes to the back of the rotation.
                    abort_o = 1'b1;
                    state_d = ST_IDLE;
                    last_d  = owner_q;
                end else begin
                    stall_d = stall_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_o     = '0;
        req_ready_o = '0;
        uio_oe_o    = 8'h00;
        uio_out_o   = 8'h00;
        if (state_q != ST_IDLE) begin
            grant_o[owner_q] = 1'b1;
        end
        if (state_q == ST_XFER) begin
            req_ready_o[owner_q] = req_valid_i[owner_q];
            if (dir_q) begin
                uio_oe_o  = 8'hFF;
                uio_out_o = req_data_i[8*int'(owner_q) +: 8];
            end
        end
    end

    assign busy_o      = (state_q != ST_IDLE);
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_data_o  = rsp_data_q;
    assign rsp_id_o    = rsp_id_q;

endmodule

// File: tb/tb_jsi_uio_arbiter.sv
// Scoreboard bench for jsi_uio_arbiter: directed bursts push expected events,
// a negedge monitor pops them as grants, write beats, read responses and aborts appear.
module tb_jsi_uio_arbiter;

    localparam int NREQ = 3;

    localparam logic [1:0] K_GRANT = 2'd0;
    localparam logic [1:0] K_WBEAT = 2'd1;
    localparam logic [1:0] K_RSP   = 2'd2;
    localparam logic [1:0] K_ABORT = 2'd3;

    typedef struct packed {
        logic [1:0] kind;
        logic [1:0] id;
        logic [7:0] data;
    } ev_t;

    logic            clk = 1'b0;
    logic            rst;
    logic            ena;
    logic [2:0]      req_valid;
    logic [2:0]      req_dir;
    logic [5:0]      req_len;
    logic [23:0]     req_data;
    logic [2:0]      req_ready;
    logic [2:0]      grant;
    logic            busy;
    logic            rsp_valid;
    logic [7:0]      rsp_data;
    logic [1:0]      rsp_id;
    logic            abort;
    logic [7:0]      uio_in;
    logic [7:0]      uio_out;
    logic [7:0]      uio_oe;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    jsi_uio_arbiter #(.NREQ(NREQ), .TURNAROUND(1), .STALL_MAX(15)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .ena_i       (ena),
        .req_valid_i (req_valid),
        .req_dir_i   (req_dir),
        .req_len_i   (req_len),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
        .grant_o     (grant),
        .busy_o      (busy),
        .rsp_valid_o (rsp_valid),
        .rsp_data_o  (rsp_data),
        .rsp_id_o    (rsp_id),
        .abort_o     (abort),
        .uio_in_i    (uio_in),
        .uio_out_o   (uio_out),
        .uio_oe_o    (uio_oe)
    );

    function automatic logic [1:0] oh2idx(input logic [2:0] g);
        if (g[2]) return 2'd2;
        if (g[1]) return 2'd1;
        return 2'd0;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [1:0] kind, input logic [1:0] id, input logic [7:0] data);
        ev_t e;
        e = '{kind: kind, id: id, data: data};
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input logic [1:0] kind, input logic [1:0] id, input logic [7:0] data);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind %0d id %0d data %0h, required no event", kind, id, data);
        end else begin
            e = exp_q.pop_front();
            if (e.kind !== kind || e.id !== id || e.data !== data) begin
                errors++;
                $display("FAIL sb_event: got kind %0d id %0d data %0h, required kind %0d id %0d data %0h",
                         kind, id, data, e.kind, e.id, e.data);
            end
        end
    endtask

    // Monitor: turns DUT activity into events and checks pad-ownership invariants.
    logic [2:0] prev_grant;
    int         low_run;
    int         oe_owner;

    always @(negedge clk) begin
        if (rst) begin
            prev_grant = '0;
            low_run    = 0;
            oe_owner   = -1;
        end else begin
            if (grant != 3'b000 && prev_grant == 3'b000) sb_pop(K_GRANT, oh2idx(grant), 8'h00);
            if (grant != 3'b000 && prev_grant != 3'b000) check("owner_stable", grant, prev_grant);
            check("ready_nonowner", req_ready & ~grant, 3'b000);
            if (|req_ready && uio_oe == 8'hFF) sb_pop(K_WBEAT, oh2idx(grant), uio_out);
            if (rsp_valid) sb_pop(K_RSP, rsp_id, rsp_data);
            if (abort) sb_pop(K_ABORT, oh2idx(grant), 8'h00);
            if (uio_oe == 8'hFF) begin
                if (oe_owner >= 0 && oe_owner != int'(oh2idx(grant)))
                    check("oe_gap", low_run >= 2, 1);
                oe_owner = int'(oh2idx(grant));
                low_run  = 0;
            end else begin
                low_run++;
            end
            prev_grant = grant;
        end
    end

    // id < 0 counts beats from any requester; rd also checks pads stay released.
    task automatic wait_beats(input int id, input int n, input bit rd);
        int cnt;
        int cyc;
        cnt = 0;
        cyc = 0;
        while (cnt < n && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (rd && grant != 3'b000) check("rd_oe", uio_oe, 8'h00);
            if (id < 0) begin
                if (|req_ready) cnt++;
            end else if (req_ready[id]) begin
                cnt++;
            end
        end
        if (cnt < n) begin
            checks++;
            errors++;
            $display("FAIL wait_beats id %0d: got %0d beats required %0d", id, cnt, n);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        ena       = 1'b1;
        req_valid = '0;
        req_dir   = '0;
        req_len   = '0;
        req_data  = '0;
        uio_in    = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_grant", grant, 3'b000);
        check("rst_busy", busy, 1'b0);
        check("rst_ready", req_ready, 3'b000);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_data", rsp_data, 8'h00);
        check("rst_rsp_id", rsp_id, 2'd0);
        check("rst_abort", abort, 1'b0);
        check("rst_uio_out", uio_out, 8'h00);
        check("rst_uio_oe", uio_oe, 8'h00);

        // Write burst, req 0, three beats.
        @(posedge clk); #1;
        req_dir  = 3'b001;
        req_len  = {2'd0, 2'd0, 2'd2};
        req_data = {8'h33, 8'h22, 8'hA5};
        push(K_GRANT, 2'd0, 8'h00);
        repeat (3) push(K_WBEAT, 2'd0, 8'hA5);
        req_valid = 3'b001;
        wait_beats(0, 3, 1'b0);
        @(posedge clk); #1 req_valid = 3'b000;
        @(negedge clk);
        check("busy_fall", busy, 1'b0);
        check("grant_fall", grant, 3'b000);

        // Round robin, all valid, single beats; last owner was 0.
        @(posedge clk); #1;
        req_dir  = 3'b111;
        req_len  = '0;
        req_data = {8'h33, 8'h22, 8'h11};
        for (int r = 0; r < 2; r++) begin
            push(K_GRANT, 2'd1, 8'h00); push(K_WBEAT, 2'd1, 8'h22);
            push(K_GRANT, 2'd2, 8'h00); push(K_WBEAT, 2'd2, 8'h33);
            push(K_GRANT, 2'd0, 8'h00); push(K_WBEAT, 2'd0, 8'h11);
        end
        req_valid = 3'b111;
        wait_beats(-1, 6, 1'b0);
        @(posedge clk); #1 req_valid = 3'b000;

        // Read burst from req 2, two beats.
        @(posedge clk); #1;
        req_dir = 3'b000;
        req_len = {2'd1, 2'd0, 2'd0};
        uio_in  = 8'h3C;
        push(K_GRANT, 2'd2, 8'h00);
        push(K_RSP, 2'd2, 8'h3C);
        push(K_RSP, 2'd2, 8'hC3);
        req_valid = 3'b100;
        wait_beats(2, 1, 1'b1);
        @(posedge clk); #1 uio_in = 8'hC3;
        wait_beats(2, 1, 1'b1);
        @(posedge clk); #1;
        req_valid = 3'b000;
        uio_in    = 8'h00;
        repeat (2) @(negedge clk);

        // Stall abort: req 0 stops after one of four beats, req 1 waits.
        @(posedge clk); #1;
        req_dir  = 3'b011;
        req_len  = {2'd0, 2'd0, 2'd3};
        req_data = {8'h00, 8'h77, 8'h5E};
        push(K_GRANT, 2'd0, 8'h00);
        push(K_WBEAT, 2'd0, 8'h5E);
        push(K_ABORT, 2'd0, 8'h00);
        push(K_GRANT, 2'd1, 8'h00);
        push(K_WBEAT, 2'd1, 8'h77);
        req_valid = 3'b001;
        wait_beats(0, 1, 1'b0);
        @(posedge clk); #1 req_valid = 3'b010;
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            check("stall_oe", uio_oe, 8'hFF);
            check("stall_abort", abort, (k == 15) ? 1'b1 : 1'b0);
        end
        wait_beats(1, 1, 1'b0);
        @(posedge clk); #1 req_valid = 3'b000;

        // Reset in the middle of a write burst from req 2.
        @(posedge clk); #1;
        req_dir  = 3'b111;
        req_len  = {2'd3, 2'd0, 2'd0};
        req_data = {8'h5A, 8'h77, 8'hC0};
        push(K_GRANT, 2'd2, 8'h00);
        repeat (2) push(K_WBEAT, 2'd2, 8'h5A);
        req_valid = 3'b100;
        wait_beats(2, 2, 1'b0);
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = 3'b000;
        @(negedge clk);
        @(negedge clk);
        check("mid_rst_oe", uio_oe, 8'h00);
        check("mid_rst_grant", grant, 3'b000);
        check("mid_rst_abort", abort, 1'b0);
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_rsp_data", rsp_data, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;
        push(K_GRANT, 2'd0, 8'h00);
        push(K_WBEAT, 2'd0, 8'hC0);
        req_valid = 3'b101;
        wait_beats(0, 1, 1'b0);
        @(posedge clk); #1 req_valid = 3'b000;

        // ena drops mid-burst; dir/len changes after grant are ignored.
        @(posedge clk); #1;
        req_dir  = 3'b010;
        req_len  = {2'd0, 2'd2, 2'd0};
        req_data = {8'h00, 8'h66, 8'h99};
        push(K_GRANT, 2'd1, 8'h00);
        repeat (3) push(K_WBEAT, 2'd1, 8'h66);
        push(K_GRANT, 2'd0, 8'h00);
        push(K_WBEAT, 2'd0, 8'h99);
        req_valid = 3'b010;
        wait_beats(1, 1, 1'b0);
        @(posedge clk); #1;
        ena       = 1'b0;
        req_valid = 3'b011;
        req_dir   = 3'b001;
        req_len   = '0;
        wait_beats(1, 2, 1'b0);
        @(posedge clk); #1 req_valid = 3'b001;
        repeat (4) begin
            @(negedge clk);
            check("ena_block", grant, 3'b000);
        end
        @(posedge clk); #1 ena = 1'b1;
        wait_beats(0, 1, 1'b0);
        @(posedge clk); #1 req_valid = 3'b000;

        repeat (4) @(negedge clk);
        check("sb_drain", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
